// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Types and constants shared by the serial sequence generator
//                and the matching 1011 detector family.
//                Contents: seq_state_t (frame FSM states), SYNC_PATTERN,
//                SYNC_LEN and a small max3() helper for counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } seq_state_t;

   // Sync preamble, transmitted MSB first.
   localparam logic [3:0] SYNC_PATTERN = 4'b1011;
   localparam int         SYNC_LEN     = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_gen_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_tx
//  Description : Framed serial transmitter. Accepts one DATA_W payload word
//                while idle and sends: 4-bit sync (1011), the payload MSB
//                first, then GAP_BITS idle zeros. Moore FSM, registered
//                outputs.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-high reset
//                data_in    - payload word, sampled on the accept edge
//                data_valid - payload offered
//                data_ready - high only in IDLE
//                outbits    - serial stream, one bit per clk
//                busy       - frame in progress (state != IDLE)
//                frame_done - pulse during the final bit of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen_tx
   import seq_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int GAP_BITS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              outbits,
   output logic              busy,
   output logic              frame_done
);

   // Counter holds the index of the bit currently on outbits within the
   // current state; it never needs to reach the longest state's length.
   localparam int CNT_MAX = max3(SYNC_LEN, DATA_W, GAP_BITS);
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] DATA_PRE  = CNT_W'((DATA_W > 1) ? DATA_W - 2 : 0);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [CNT_W-1:0] GAP_PRE   = CNT_W'((GAP_BITS > 1) ? GAP_BITS - 2 : 0);
   localparam logic             HAS_GAP   = (GAP_BITS > 0);

   seq_state_t          state;
   logic [DATA_W-1:0]   shreg;
   logic [CNT_W-1:0]    cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         cnt        <= '0;
         outbits    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt        <= '0;
               frame_done <= 1'b0;
               if (data_valid) begin
                  shreg   <= data_in;
                  state   <= ST_SYNC;
                  outbits <= SYNC_PATTERN[SYNC_LEN-1];
               end else begin
                  outbits <= 1'b0;
               end
            end

            ST_SYNC: begin
               if (cnt == SYNC_LAST) begin
                  // First payload bit goes out as we enter DATA.
                  state      <= ST_DATA;
                  cnt        <= '0;
                  outbits    <= shreg[DATA_W-1];
                  shreg      <= shreg << 1;
                  frame_done <= !HAS_GAP && (DATA_W == 1);
               end else begin
                  cnt        <= cnt + 1'b1;
                  // Next pattern bit, MSB first: index 2 - cnt.
                  outbits    <= SYNC_PATTERN[2'(SYNC_LEN - 2) - cnt[1:0]];
                  frame_done <= 1'b0;
               end
            end

            ST_DATA: begin
               if (cnt == DATA_LAST) begin
                  cnt     <= '0;
                  outbits <= 1'b0;
                  if (HAS_GAP) begin
                     state      <= ST_GAP;
                     frame_done <= (GAP_BITS == 1);
                  end else begin
                     state      <= ST_IDLE;
                     frame_done <= 1'b0;
                  end
               end else begin
                  cnt        <= cnt + 1'b1;
                  outbits    <= shreg[DATA_W-1];
                  shreg      <= shreg << 1;
                  frame_done <= !HAS_GAP && (cnt == DATA_PRE);
               end
            end

            ST_GAP: begin
               outbits <= 1'b0;
               if (cnt == GAP_LAST) begin
                  state      <= ST_IDLE;
                  cnt        <= '0;
                  frame_done <= 1'b0;
               end else begin
                  cnt        <= cnt + 1'b1;
                  frame_done <= (cnt == GAP_PRE);
               end
            end

            default: begin
               state      <= ST_IDLE;
               cnt        <= '0;
               outbits    <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

   assign data_ready = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);

endmodule
`default_nettype wire
